// File: rtl/ex_mem_flag_stage_pkg.sv
// Shared definitions for the EX/MEM boundary: ALU op codes, branch condition
// codes, flag bit positions and the MEM latch payload layout.
package ex_mem_flag_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int FLAG_W = 3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_XOR  = 3'b011;
    localparam logic [2:0] ALU_INC  = 3'b100;
    localparam logic [2:0] ALU_SRA  = 3'b101;
    localparam logic [2:0] ALU_SRL  = 3'b110;
    localparam logic [2:0] ALU_SLL  = 3'b111;

    localparam logic [2:0] COND_NEQ    = 3'b000;
    localparam logic [2:0] COND_EQ     = 3'b001;
    localparam logic [2:0] COND_GT     = 3'b010;
    localparam logic [2:0] COND_LT     = 3'b011;
    localparam logic [2:0] COND_GTE    = 3'b100;
    localparam logic [2:0] COND_LTE    = 3'b101;
    localparam logic [2:0] COND_OVFL   = 3'b110;
    localparam logic [2:0] COND_UNCOND = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef struct packed {
        logic              valid;
        logic              reg_we;
        logic              mem_re;
        logic              mem_we;
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] store_data;
    } mem_payload_t;

    // Arithmetic/logic ops update the flags; the three shifts do not.
    function automatic logic op_sets_flags(input logic [2:0] op);
        return op <= ALU_INC;
    endfunction

endpackage

// File: rtl/ex_mem_flag_stage_branch_cond_eval.sv
// Combinational evaluation of a branch condition code against [Z,V,N] flags.
module branch_cond_eval
    import ex_mem_flag_stage_pkg::*;
(
    input  logic [FLAG_W-1:0] flags,
    input  logic [2:0]        cond,
    output logic              taken
);

    logic z;
    logic v;
    logic n;

    assign z = flags[FLAG_Z];
    assign v = flags[FLAG_V];
    assign n = flags[FLAG_N];

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_NEQ:    taken = ~z;
            COND_EQ:     taken = z;
            COND_GT:     taken = ~z & ~n;
            COND_LT:     taken = n;
            COND_GTE:    taken = z | ~n;
            COND_LTE:    taken = n | z;
            COND_OVFL:   taken = v;
            COND_UNCOND: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/ex_mem_flag_stage.sv
// EX-to-MEM stage: commits ALU flags, resolves conditional branches against
// the committed flags, and latches the EX payload into the MEM pipeline slot.
module ex_mem_flag_stage
    import ex_mem_flag_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              ex_valid,
    input  logic [2:0]        ex_alu_op,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [FLAG_W-1:0] ex_alu_flags,
    input  logic              ex_is_branch,
    input  logic [2:0]        ex_cond,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic [DATA_W-1:0] ex_store_data,
    output logic              mem_valid,
    output logic              mem_reg_we,
    output logic              mem_mem_re,
    output logic              mem_mem_we,
    output logic [DATA_W-1:0] mem_result,
    output logic [REG_W-1:0]  mem_rd,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [FLAG_W-1:0] flags_q,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic [DATA_W-1:0] branch_cnt
);

    logic         ev;
    logic         cond_true;
    logic         alu_slot;
    mem_payload_t mem_q;

    // The instruction right behind a taken branch is wrong-path and is dropped.
    assign ev       = ex_valid & ~branch_taken;
    assign alu_slot = ev & ~ex_is_branch;

    branch_cond_eval u_cond (
        .flags (flags_q),
        .cond  (ex_cond),
        .taken (cond_true)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q       <= '0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
            branch_cnt    <= '0;
            mem_q         <= '0;
        end else if (!stall) begin
            if (alu_slot && op_sets_flags(ex_alu_op)) begin
                flags_q <= ex_alu_flags;
            end

            if (ev && ex_is_branch && cond_true) begin
                branch_taken  <= 1'b1;
                branch_target <= ex_branch_target;
                branch_cnt    <= branch_cnt + 16'd1;
            end else begin
                branch_taken  <= 1'b0;
            end

            // Payload always loads; controls are qualified so a bubble never writes.
            mem_q.valid      <= alu_slot;
            mem_q.reg_we     <= alu_slot & ex_reg_we;
            mem_q.mem_re     <= alu_slot & ex_mem_re;
            mem_q.mem_we     <= alu_slot & ex_mem_we;
            mem_q.result     <= ex_alu_result;
            mem_q.rd         <= ex_rd;
            mem_q.store_data <= ex_store_data;
        end
    end

    assign mem_valid      = mem_q.valid;
    assign mem_reg_we     = mem_q.reg_we;
    assign mem_mem_re     = mem_q.mem_re;
    assign mem_mem_we     = mem_q.mem_we;
    assign mem_result     = mem_q.result;
    assign mem_rd         = mem_q.rd;
    assign mem_store_data = mem_q.store_data;

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Directed scenarios plus a randomized run of ex_mem_flag_stage, checked
// against a behavioural model of the stage's flag, branch and MEM-latch rules.
module tb_ex_mem_flag_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic [2:0]  ex_alu_op;
    logic [15:0] ex_alu_result;
    logic [2:0]  ex_alu_flags;
    logic        ex_is_branch;
    logic [2:0]  ex_cond;
    logic [15:0] ex_branch_target;
    logic [3:0]  ex_rd;
    logic        ex_reg_we;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [15:0] ex_store_data;
    logic        mem_valid;
    logic        mem_reg_we;
    logic        mem_mem_re;
    logic        mem_mem_we;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic [15:0] mem_store_data;
    logic [2:0]  flags_q;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] branch_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Expected architectural state, advanced once per rising edge.
    logic [2:0]  m_flags;
    logic        m_bt;
    logic [15:0] m_tgt;
    logic [15:0] m_cnt;
    logic        m_valid;
    logic        m_rwe;
    logic        m_re;
    logic        m_we;
    logic [15:0] m_result;
    logic [3:0]  m_rd;
    logic [15:0] m_sd;

    always #5 clk = ~clk;

    ex_mem_flag_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_alu_op        (ex_alu_op),
        .ex_alu_result    (ex_alu_result),
        .ex_alu_flags     (ex_alu_flags),
        .ex_is_branch     (ex_is_branch),
        .ex_cond          (ex_cond),
        .ex_branch_target (ex_branch_target),
        .ex_rd            (ex_rd),
        .ex_reg_we        (ex_reg_we),
        .ex_mem_re        (ex_mem_re),
        .ex_mem_we        (ex_mem_we),
        .ex_store_data    (ex_store_data),
        .mem_valid        (mem_valid),
        .mem_reg_we       (mem_reg_we),
        .mem_mem_re       (mem_mem_re),
        .mem_mem_we       (mem_mem_we),
        .mem_result       (mem_result),
        .mem_rd           (mem_rd),
        .mem_store_data   (mem_store_data),
        .flags_q          (flags_q),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .branch_cnt       (branch_cnt)
    );

    function automatic logic cond_holds(input logic [2:0] f, input logic [2:0] c);
        logic z;
        logic v;
        logic n;
        z = f[2];
        v = f[1];
        n = f[0];
        case (c)
            3'd0:    return !z;
            3'd1:    return z;
            3'd2:    return !z && !n;
            3'd3:    return n;
            3'd4:    return z || !n;
            3'd5:    return n || z;
            3'd6:    return v;
            default: return 1'b1;
        endcase
    endfunction

    // Applies one clock's worth of stage rules to the expected state.
    task automatic model_step();
        logic live;
        logic take;
        if (rst) begin
            m_flags = 3'b000; m_bt = 1'b0; m_tgt = 16'h0; m_cnt = 16'h0;
            m_valid = 1'b0; m_rwe = 1'b0; m_re = 1'b0; m_we = 1'b0;
            m_result = 16'h0; m_rd = 4'h0; m_sd = 16'h0;
        end else if (!stall) begin
            live = ex_valid && !m_bt;
            take = live && ex_is_branch && cond_holds(m_flags, ex_cond);
            if (live && !ex_is_branch && ex_alu_op <= 3'd4) m_flags = ex_alu_flags;
            if (take) begin
                m_tgt = ex_branch_target;
                m_cnt = m_cnt + 16'd1;
            end
            m_bt     = take;
            m_valid  = live && !ex_is_branch;
            m_rwe    = m_valid && ex_reg_we;
            m_re     = m_valid && ex_mem_re;
            m_we     = m_valid && ex_mem_we;
            m_result = ex_alu_result;
            m_rd     = ex_rd;
            m_sd     = ex_store_data;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_alu_op = 3'd0; ex_alu_result = 16'h0; ex_alu_flags = 3'd0;
        ex_is_branch = 1'b0; ex_cond = 3'd0; ex_branch_target = 16'h0; ex_rd = 4'h0;
        ex_reg_we = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b0; ex_store_data = 16'h0;
    endtask

    task automatic drive_alu(input logic [2:0] op, input logic [15:0] res,
                             input logic [2:0] fl, input logic [3:0] rd, input logic we);
        ex_valid = 1'b1; ex_is_branch = 1'b0; ex_alu_op = op; ex_alu_result = res;
        ex_alu_flags = fl; ex_rd = rd; ex_reg_we = we; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
        ex_store_data = 16'($urandom); ex_cond = 3'($urandom); ex_branch_target = 16'($urandom);
    endtask

    task automatic drive_branch(input logic [2:0] cond, input logic [15:0] target);
        ex_valid = 1'b1; ex_is_branch = 1'b1; ex_cond = cond; ex_branch_target = target;
        ex_alu_op = 3'($urandom); ex_alu_result = 16'($urandom); ex_alu_flags = 3'($urandom);
        ex_rd = 4'($urandom); ex_reg_we = 1'b1; ex_mem_re = 1'b0; ex_mem_we = 1'b0;
        ex_store_data = 16'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0;
        drive_alu(3'd0, 16'hBEEF, 3'b111, 4'd5, 1'b1);
        cycle();
        vectors++; if (flags_q !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_flags: got %b want 000", flags_q); end
        vectors++; if (branch_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bt: got %b want 0", branch_taken); end
        vectors++; if (branch_cnt !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %h want 0000", branch_cnt); end
        vectors++; if (mem_valid !== 1'b0 || mem_reg_we !== 1'b0 || mem_result !== 16'h0) begin
            miscompares++; $display("[TB] FAIL reset_mem: got v=%b we=%b res=%h want 0/0/0000", mem_valid, mem_reg_we, mem_result);
        end
        rst = 1'b0;
        drive_idle();
        cycle();
        vectors++; if ({mem_valid, mem_reg_we, mem_mem_re, mem_mem_we, mem_result, mem_rd, mem_store_data,
                        flags_q, branch_taken, branch_target, branch_cnt} !== '0) begin
            miscompares++; $display("[TB] FAIL idle_all_zero: got res=%h flags=%b bt=%b tgt=%h cnt=%h want all 0",
                                    mem_result, flags_q, branch_taken, branch_target, branch_cnt);
        end
    endtask

    task automatic test_flag_commit();
        drive_alu(3'd0, 16'h1111, 3'b100, 4'd1, 1'b1);
        cycle();
        vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("[TB] FAIL add_flags: got %b want 100", flags_q); end
        vectors++; if (mem_valid !== 1'b1 || mem_reg_we !== 1'b1 || mem_result !== 16'h1111 || mem_rd !== 4'd1) begin
            miscompares++; $display("[TB] FAIL add_mem: got v=%b we=%b res=%h rd=%h want 1/1/1111/1", mem_valid, mem_reg_we, mem_result, mem_rd);
        end
        drive_alu(3'd7, 16'h2222, 3'b001, 4'd2, 1'b0);
        cycle();
        vectors++; if (flags_q !== 3'b100) begin miscompares++; $display("[TB] FAIL sll_keeps_flags: got %b want 100", flags_q); end
        vectors++; if (mem_valid !== 1'b1 || mem_reg_we !== 1'b0) begin
            miscompares++; $display("[TB] FAIL sll_mem: got v=%b we=%b want 1/0", mem_valid, mem_reg_we);
        end
    endtask

    task automatic test_branch_lt();
        drive_alu(3'd1, 16'h0005, 3'b001, 4'd4, 1'b1);
        cycle();
        drive_branch(3'd3, 16'h0040);
        cycle();
        vectors++; if (branch_taken !== 1'b1) begin miscompares++; $display("[TB] FAIL lt_taken: got %b want 1", branch_taken); end
        vectors++; if (branch_target !== 16'h0040) begin miscompares++; $display("[TB] FAIL lt_target: got %h want 0040", branch_target); end
        vectors++; if (branch_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL lt_cnt: got %h want 0001", branch_cnt); end
        vectors++; if (mem_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL lt_slot_valid: got %b want 0", mem_valid); end
        drive_alu(3'd0, 16'h3333, 3'b100, 4'd3, 1'b1);
        cycle();
        vectors++; if (mem_valid !== 1'b0 || mem_reg_we !== 1'b0) begin
            miscompares++; $display("[TB] FAIL squash_mem: got v=%b we=%b want 0/0", mem_valid, mem_reg_we);
        end
        vectors++; if (flags_q !== 3'b001) begin miscompares++; $display("[TB] FAIL squash_flags: got %b want 001", flags_q); end
        vectors++; if (branch_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL pulse_width: got %b want 0", branch_taken); end
    endtask

    task automatic test_not_taken();
        drive_alu(3'd0, 16'h0000, 3'b100, 4'd6, 1'b1);
        cycle();
        drive_branch(3'd0, 16'h0100);
        cycle();
        vectors++; if (branch_taken !== 1'b0) begin miscompares++; $display("[TB] FAIL neq_not_taken: got %b want 0", branch_taken); end
        vectors++; if (branch_cnt !== 16'd1) begin miscompares++; $display("[TB] FAIL neq_cnt: got %h want 0001", branch_cnt); end
        drive_branch(3'd7, 16'h0200);
        cycle();
        vectors++; if (branch_taken !== 1'b1 || branch_target !== 16'h0200) begin
            miscompares++; $display("[TB] FAIL uncond_taken: got bt=%b tgt=%h want 1/0200", branch_taken, branch_target);
        end
        vectors++; if (branch_cnt !== 16'd2) begin miscompares++; $display("[TB] FAIL uncond_cnt: got %h want 0002", branch_cnt); end
    endtask

    task automatic test_stall();
        drive_idle();
        cycle();
        drive_branch(3'd7, 16'h0ABC);
        cycle();
        stall = 1'b1;
        drive_branch(3'd7, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            cycle();
            vectors++; if (branch_taken !== 1'b1 || branch_target !== 16'h0ABC || branch_cnt !== 16'd3) begin
                miscompares++; $display("[TB] FAIL stall_hold[%0d]: got bt=%b tgt=%h cnt=%h want 1/0abc/0003",
                                        i, branch_taken, branch_target, branch_cnt);
            end
        end
        stall = 1'b0;
        cycle();
        vectors++; if (branch_taken !== 1'b0 || branch_cnt !== 16'd3) begin
            miscompares++; $display("[TB] FAIL stall_release: got bt=%b cnt=%h want 0/0003", branch_taken, branch_cnt);
        end
    endtask

    task automatic test_wrap();
        drive_idle();
        cycle();
        force dut.branch_cnt = 16'hFFFF;
        #1;
        release dut.branch_cnt;
        m_cnt = 16'hFFFF;
        drive_branch(3'd7, 16'h0F0F);
        cycle();
        vectors++; if (branch_cnt !== 16'h0000 || branch_taken !== 1'b1) begin
            miscompares++; $display("[TB] FAIL cnt_wrap: got cnt=%h bt=%b want 0000/1", branch_cnt, branch_taken);
        end
        rst = 1'b1; stall = 1'b1;
        drive_alu(3'd0, 16'h5555, 3'b010, 4'd7, 1'b1);
        cycle();
        vectors++; if (branch_taken !== 1'b0 || flags_q !== 3'b000 || mem_valid !== 1'b0 || branch_target !== 16'h0) begin
            miscompares++; $display("[TB] FAIL rst_over_stall: got bt=%b flags=%b v=%b tgt=%h want 0/000/0/0000",
                                    branch_taken, flags_q, mem_valid, branch_target);
        end
        rst = 1'b0; stall = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 7) == 0);
            ex_valid = ($urandom_range(0, 3) != 0);
            ex_is_branch = ($urandom_range(0, 2) == 0);
            ex_alu_op = 3'($urandom); ex_alu_result = 16'($urandom); ex_alu_flags = 3'($urandom);
            ex_cond = 3'($urandom); ex_branch_target = 16'($urandom); ex_rd = 4'($urandom);
            ex_reg_we = 1'($urandom); ex_mem_re = 1'($urandom); ex_mem_we = 1'($urandom);
            ex_store_data = 16'($urandom);
            cycle();
            vectors++;
            if (flags_q !== m_flags || branch_taken !== m_bt || branch_target !== m_tgt || branch_cnt !== m_cnt ||
                mem_valid !== m_valid || mem_reg_we !== m_rwe || mem_mem_re !== m_re || mem_mem_we !== m_we ||
                mem_result !== m_result || mem_rd !== m_rd || mem_store_data !== m_sd) begin
                miscompares++;
                $display("[TB] FAIL random[%0d]: got fl=%b bt=%b tgt=%h cnt=%h v=%b we=%b re=%b mw=%b res=%h rd=%h sd=%h want fl=%b bt=%b tgt=%h cnt=%h v=%b we=%b re=%b mw=%b res=%h rd=%h sd=%h",
                         i, flags_q, branch_taken, branch_target, branch_cnt, mem_valid, mem_reg_we, mem_mem_re, mem_mem_we,
                         mem_result, mem_rd, mem_store_data, m_flags, m_bt, m_tgt, m_cnt, m_valid, m_rwe, m_re, m_we,
                         m_result, m_rd, m_sd);
            end
        end
        rst = 1'b0; stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        drive_idle();
        @(negedge clk);
        test_reset();
        test_flag_commit();
        test_branch_lt();
        test_not_taken();
        test_stall();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_mem_flag_stage.md
# ex_mem_flag_stage

Execute-to-memory boundary stage that consumes the ALU's result and [Z,V,N] flags. It commits flags into the architectural flag register, resolves conditional branches against that register, and registers the EX payload into the MEM pipeline latch. It issues a one-cycle branch-taken/redirect pulse that also squashes the wrong-path instruction following the branch.

## Interface
- No parameters; data width fixed at 16, register index at 4, flags at 3.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- stall  in  1  freeze every register in the stage
- ex_valid  in  1  EX slot holds a real instruction
- ex_alu_op  in  3  ALU control code: 000 ADD, 001 SUB, 010 NAND, 011 XOR, 100 INC, 101 SRA, 110 SRL, 111 SLL
- ex_alu_result  in  16  ALU result
- ex_alu_flags  in  3  ALU flags [Z,V,N]
- ex_is_branch  in  1  EX instruction is a conditional branch (ALU outputs ignored)
- ex_cond  in  3  branch condition code
- ex_branch_target  in  16  branch target address
- ex_rd  in  4  destination register
- ex_reg_we  in  1  register-file write
- ex_mem_re  in  1  memory read
- ex_mem_we  in  1  memory write
- ex_store_data  in  16  store data
- mem_valid, mem_reg_we, mem_mem_re, mem_mem_we  out  1 each  registered MEM controls
- mem_result  out  16  registered ALU result / memory address
- mem_rd  out  4  registered destination
- mem_store_data  out  16  registered store data
- flags_q  out  3  architectural flags [Z,V,N]
- branch_taken  out  1  registered one-cycle redirect pulse
- branch_target  out  16  registered redirect address, valid while branch_taken=1
- branch_cnt  out  16  count of taken branches, wraps

## Operation
- Effective valid: ev = ex_valid & ~branch_taken. An EX instruction arriving while branch_taken=1 is wrong-path and is squashed.
- Flag commit: if ev & ~ex_is_branch & ex_alu_op ≤ 100, then flags_q <= ex_alu_flags. Shifts (101–111) and branches leave flags_q unchanged.
- Branch conditions use the current flags_q (Z,V,N), never same-cycle ex_alu_flags:
  - 000 NEQ: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z & ~N
  - 011 LT: N
  - 100 GTE: Z | ~N
  - 101 LTE: N | Z
  - 110 OVFL: V
  - 111 UNCOND: 1
- Redirect: if ev & ex_is_branch & cond is true, then branch_taken <= 1, branch_target <= ex_branch_target, and branch_cnt increments by 1, wrapping from 0xFFFF to 0x0000. Otherwise branch_taken <= 0 and branch_target holds.
- MEM latch: mem_valid <= ev & ~ex_is_branch. Payload fields load every non-stalled cycle. When mem_valid=0, mem_reg_we, mem_mem_re and mem_mem_we are forced to 0.
- Stall: all registers hold, including branch_taken (the pulse is extended for the stall duration). Upstream also holds under stall.
- Reset: flags_q=000, branch_taken=0, branch_target=0, branch_cnt=0, mem_valid=0, all mem_* data and control outputs 0. Reset overrides stall and any in-flight branch.

## Timing
- All outputs are registered and update on the rising clk edge after the EX inputs are sampled. Latency is 1 cycle.
- A flag-setting op at cycle t updates flags_q at t+1. A branch in EX at t+1 therefore sees the new flags with no bubble.
- A branch taken at t raises branch_taken during t+1. The instruction presented in EX at t+1 is squashed: no flag update, no MEM write, and no branch.
- Back-to-back branches: the second branch is squashed whenever the first was taken.
- Simultaneous stall and rst: rst wins.

## Structure
- Shared package: ALU op localparams (ADD…SLL), condition-code localparams (NEQ…UNCOND), and flag bit indices Z=2, V=1, N=0. The ALU shares the same package.
- One sub-module, branch_cond_eval: purely combinational; inputs flags and cond, output taken.

## Test plan
- Reset, then idle: all outputs 0; flags_q=000 after rst is held for 1 cycle with ex_valid=1.
- ADD with flags 100, then SLL with flags 001: flags_q=100 after the first edge and still 100 after the second.
- SUB setting flags 001, next cycle branch LT to 0x0040: branch_taken=1 for exactly one cycle, branch_target=0x0040, branch_cnt=1, mem_valid=0 for the branch slot.
- Taken branch followed by ADD (rd=3, reg_we=1, flags 100): ADD squashed; mem_valid=0, mem_reg_we=0, flags_q unchanged.
- Branch NEQ with flags_q=100: branch_taken stays 0 and branch_cnt is unchanged; then UNCOND branch: taken.
- Stall asserted for 2 cycles during branch_taken=1: all outputs frozen and the pulse lasts 3 cycles. With branch_cnt preloaded to 0xFFFF, one more taken branch wraps it to 0x0000.
